divide_collect: RTL and testbench
=================================

DIVIDE_COLLECT -- requirements
Module: divide_collect

Interface
REQ-001 SHALL have parameter Q_BITS, default 10, fractional bits of each quotient (metadata only, no arithmetic use).
REQ-002 SHALL have parameter D_BITS, default 32, width of one quotient word.
REQ-003 SHALL have parameter N_LANES, default 3, number of quotients per output vector (legal 1..8).
REQ-004 SHALL have ports:
  clock      in   1                  single clock, all logic rising-edge.
  reset      in   1                  asynchronous, active-low (asserted at 0).
  in_empty   in   1                  quotient FIFO empty flag.
  in_rd_en   out  1                  quotient FIFO pop strobe.
  in_dout    in   D_BITS signed      quotient FIFO read data.
  flush      in   1                  discard partially assembled vector.
  vec_dout   out  N_LANES*D_BITS     assembled vector; lane 0 in bits [D_BITS-1:0].
  vec_valid  out  1                  vec_dout holds a complete vector.
  vec_ready  in   1                  downstream accepts vector.
REQ-005 SHALL, with DIVIDE_COLLECT_CNT_EN defined, also have vec_count out 32 (number of vectors accepted since reset).

Function
REQ-006 SHALL act as reader of the divider output FIFO: in_dout is valid on the cycle after in_rd_en is asserted.
REQ-007 SHALL implement FSM states S_REQ, S_CAP, S_OUT; lane index idx of width clog2(N_LANES)+1.
REQ-008 S_REQ: if in_empty=0 assert in_rd_en for exactly one cycle and go S_CAP; else stay, in_rd_en=0.
REQ-009 S_CAP: in_rd_en=0; write in_dout into lane[idx]; if idx==N_LANES-1 go S_OUT with idx=0, else idx+1 and go S_REQ.
REQ-010 S_OUT: vec_valid=1, vec_dout stable, in_rd_en=0; on vec_ready=1 go S_REQ; otherwise hold indefinitely.
REQ-011 SHALL never assert in_rd_en while in_empty=1 or outside S_REQ.
REQ-012 Latency: vec_valid rises the cycle after the S_CAP of lane N_LANES-1; minimum 2*N_LANES+1 cycles from first pop to handshake; throughput one word per 2 cycles.
REQ-013 Lanes SHALL be stored unmodified (no sign extension, rounding or rescaling).
REQ-014 flush=1 in S_REQ or S_CAP: idx:=0, state:=S_REQ next cycle, word popped in that S_CAP discarded, in_rd_en=0 that cycle.
REQ-015 flush=1 in S_OUT SHALL be ignored; completed vectors are never dropped.
REQ-016 flush and vec_ready together in S_OUT: handshake completes normally.
REQ-017 vec_count SHALL increment by 1 per vec_valid&&vec_ready cycle, wrapping 2^32-1 -> 0.

Reset
REQ-018 reset=0 SHALL immediately force state S_REQ, idx=0, in_rd_en=0, vec_valid=0, vec_dout=0, vec_count=0.
REQ-019 Reset mid-vector SHALL discard all captured lanes; a word popped but not captured is lost.

Configuration
REQ-020 Macro DIVIDE_COLLECT_CNT_EN: defined -> vec_count port and counter present; undefined -> port and counter absent, all other behaviour identical.

Structure
REQ-021 Shared package divide_pkg SHALL hold the FSM state enum and default D_BITS/Q_BITS constants, shared with the divider.
REQ-022 No sub-module; a single always_ff for state/idx/lanes plus a combinational output block.

Verification
REQ-023 N_LANES=3, FIFO preloaded 0x00000400,0xFFFFFC00,0x00000200, vec_ready=1 -> vec_dout={0x200,0xFFFFFC00,0x400}, vec_valid one cycle.
REQ-024 vec_ready=0 for 20 cycles after vector ready, FIFO holding 4 more words -> vec_dout stable, in_rd_en never asserted until handshake.
REQ-025 in_empty=1 between each word for 5 cycles -> in_rd_en only when in_empty=0, one pulse per word, correct lane order.
REQ-026 flush asserted in S_CAP of lane 1 -> next vector built from the following 3 FIFO words, lanes 0-1 of aborted vector absent.
REQ-027 reset=0 asserted asynchronously mid-S_OUT -> vec_valid=0 same cycle; after release, first vector correct from next FIFO words.
REQ-028 CNT_EN defined, 5 handshakes -> vec_count=5; counter preset near 0xFFFFFFFF (force) wraps to 0.

Source files
------------

// File: rtl/divide_pkg.sv
// Shared divider definitions: default quotient format and the collector's FSM state encoding.
package divide_pkg;

  localparam int D_BITS_DEF = 32;
  localparam int Q_BITS_DEF = 10;

  typedef logic [1:0] state_t;

  localparam state_t S_REQ = 2'd0;
  localparam state_t S_CAP = 2'd1;
  localparam state_t S_OUT = 2'd2;

endpackage

// File: rtl/divide_collect.sv
// Pops quotients from the divider FIFO and packs N_LANES of them into one vector (lane 0 in the LSBs).
// Optional macro DIVIDE_COLLECT_CNT_EN adds the vec_count port counting accepted vectors.
module divide_collect
  import divide_pkg::*;
#(
  parameter int Q_BITS  = Q_BITS_DEF,
  parameter int D_BITS  = D_BITS_DEF,
  parameter int N_LANES = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_empty,
  output logic                        in_rd_en,
  input  logic signed [D_BITS-1:0]    in_dout,
  input  logic                        flush,
  output logic [N_LANES*D_BITS-1:0]   vec_dout,
  output logic                        vec_valid,
  input  logic                        vec_ready
`ifdef DIVIDE_COLLECT_CNT_EN
  ,
  output logic [31:0]                 vec_count
`endif
);

  localparam int IDX_W = $clog2(N_LANES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

  if (N_LANES < 1 || N_LANES > 8 || Q_BITS > D_BITS) begin : g_cfg_check
    $error("divide_collect: illegal parameter combination");
  end

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [N_LANES*D_BITS-1:0]   r_vec;

  // FSM, lane index and lane storage; in_dout is only valid in S_CAP, one cycle after the pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
      r_idx   <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (flush) begin
            r_idx   <= '0;
            r_state <= S_REQ;
          end else if (!in_empty) begin
            r_state <= S_CAP;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_CAP: begin
          if (flush) begin
            r_idx   <= '0;
            r_state <= S_REQ;
          end else begin
            for (int l = 0; l < N_LANES; l++) begin
              if (r_idx == IDX_W'(l)) begin
                r_vec[l*D_BITS +: D_BITS] <= in_dout;
              end
            end
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= S_OUT;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_REQ;
            end
          end
        end
        // A completed vector is held until accepted; flush cannot drop it.
        S_OUT: begin
          if (vec_ready) begin
            r_state <= S_REQ;
          end else begin
            r_state <= S_OUT;
          end
        end
        default: begin
          r_state <= S_REQ;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Strobes decoded from state so reset clears them without waiting for a clock edge.
  always_comb begin
    in_rd_en  = 1'b0;
    vec_valid = 1'b0;
    case (r_state)
      S_REQ: begin
        in_rd_en  = !in_empty && !flush;
        vec_valid = 1'b0;
      end
      S_OUT: begin
        in_rd_en  = 1'b0;
        vec_valid = 1'b1;
      end
      default: begin
        in_rd_en  = 1'b0;
        vec_valid = 1'b0;
      end
    endcase
    vec_dout = r_vec;
  end

`ifdef DIVIDE_COLLECT_CNT_EN
  logic [31:0] r_vec_count;

  // Accepted-vector counter, wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vec_count <= 32'd0;
    end else if (vec_valid && vec_ready) begin
      r_vec_count <= r_vec_count + 32'd1;
    end
  end

  assign vec_count = r_vec_count;
`endif

endmodule

// File: tb/tb_divide_collect.sv
// Bench for divide_collect: FIFO model feeding the DUT, scoreboard of expected vectors checked on handshake.
// Define DIVIDE_COLLECT_CNT_EN to also exercise vec_count.
module tb_divide_collect;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_empty = 1'b1;
  logic               in_rd_en;
  logic signed [31:0] in_dout = 32'sd0;
  logic               flush;
  logic [95:0]        vec_dout;
  logic               vec_valid;
  logic               vec_ready;
`ifdef DIVIDE_COLLECT_CNT_EN
  logic [31:0]        vec_count;
`endif

  divide_collect #(.Q_BITS(10), .D_BITS(32), .N_LANES(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .in_dout   (in_dout),
    .flush     (flush),
    .vec_dout  (vec_dout),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready)
`ifdef DIVIDE_COLLECT_CNT_EN
    ,
    .vec_count (vec_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [95:0] exp;
  } rec_t;

  rec_t        tbl [4];
  logic [31:0] fifo_q [$];
  logic [95:0] exp_q  [$];
  int          checks   = 0;
  int          errors   = 0;
  int          rd_viol  = 0;
  int          pulse_cnt = 0;
  int          hs_cnt   = 0;

  // Divider FIFO model: data appears the cycle after the pop.
  always @(posedge clock) begin
    if (in_rd_en && fifo_q.size() > 0) begin
      in_dout <= fifo_q.pop_front();
    end
    in_empty <= (fifo_q.size() == 0);
  end

  // Monitor and scoreboard check on every accepted vector.
  always @(negedge clock) begin
    if (reset) begin
      if (in_rd_en && in_empty) rd_viol++;
      if (in_rd_en) pulse_cnt++;
      if (vec_valid && vec_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got vector %h, none expected", vec_dout);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if (vec_dout !== e) begin
            errors++;
            $display("FAIL sb_vector: got %h expected %h", vec_dout, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic push_vec(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [95:0] e);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    exp_q.push_back(e);
  endtask

  task automatic wait_rd(input int budget, input string name);
    int n = 0;
    @(negedge clock);
    while (!in_rd_en && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!in_rd_en) begin
      checks++;
      errors++;
      $display("FAIL %s: no in_rd_en within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    @(negedge clock);
    while (!vec_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!vec_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: no vec_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d vectors outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int  n;
    int  p0;
    bit  ok;

    tbl[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 96'h00000003_00000002_00000001};
    tbl[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 96'hFFFFFFFF_7FFFFFFF_80000000};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 96'h00000000_00000000_00000000};
    tbl[3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 96'hA5A5A5A5_12345678_DEADBEEF};

    reset = 1'b0;
    flush = 1'b0;
    vec_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_valid", 96'(vec_valid), 96'd0);
    chk("reset_rd_en", 96'(in_rd_en), 96'd0);
    chk("reset_dout",  vec_dout,       96'd0);

    // Basic vector with ready high: latency from first pop and single-cycle valid.
    @(posedge clock); #1;
    reset = 1'b1;
    vec_ready = 1'b1;
    push_vec(32'h0000_0400, 32'hFFFF_FC00, 32'h0000_0200, 96'h00000200_FFFFFC00_00000400);
    wait_rd(20, "first_pop");
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!vec_valid && n < 20);
    chk("latency_cycles", 96'(n), 96'd6);
    @(negedge clock);
    chk("valid_one_cycle", 96'(vec_valid), 96'd0);
    drain(20, "basic_drain");

    // Table of back-to-back vectors.
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      push_vec(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].exp);
    end
    drain(100, "table_drain");

    // Backpressure: vector held stable, no pops, while more words wait.
    @(posedge clock); #1;
    vec_ready = 1'b0;
    push_vec(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 96'h33330000_22220000_11110000);
    wait_valid(30, "bp_valid");
    @(posedge clock); #1;
    push_word(32'h0000_0A01);
    push_word(32'h0000_0A02);
    push_word(32'h0000_0A03);
    push_word(32'h0000_0A04);
    exp_q.push_back(96'h00000A03_00000A02_00000A01);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (vec_dout !== exp_q[0] || in_rd_en || !vec_valid) ok = 1'b0;
    end
    chk("bp_hold_stable", 96'(ok), 96'd1);
    @(posedge clock); #1;
    vec_ready = 1'b1;
    push_word(32'h0000_0A05);
    push_word(32'h0000_0A06);
    exp_q.push_back(96'h00000A06_00000A05_00000A04);
    drain(100, "bp_drain");

    // Sparse FIFO: one pop per word, lanes still in order.
    p0 = pulse_cnt;
    exp_q.push_back(96'hCCCC0003_BBBB0002_AAAA0001);
    @(posedge clock); #1;
    push_word(32'hAAAA_0001);
    repeat (7) @(posedge clock);
    #1 push_word(32'hBBBB_0002);
    repeat (7) @(posedge clock);
    #1 push_word(32'hCCCC_0003);
    drain(40, "sparse_drain");
    chk("sparse_pulses", 96'(pulse_cnt - p0), 96'd3);

    // Flush during the capture of lane 1 discards the partial vector.
    @(posedge clock); #1;
    push_word(32'hBAD0_0000);
    push_word(32'hBAD0_0001);
    wait_rd(20, "flush_pop0");
    wait_rd(20, "flush_pop1");
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    push_vec(32'h0F0F_0001, 32'h0F0F_0002, 32'h0F0F_0003, 96'h0F0F0003_0F0F0002_0F0F0001);
    drain(40, "flush_drain");

    // Flush in S_OUT is ignored, and flush with ready still hands off.
    @(posedge clock); #1;
    vec_ready = 1'b0;
    push_vec(32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 96'h55550003_55550002_55550001);
    wait_valid(30, "out_flush_valid");
    @(posedge clock); #1;
    flush = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (!vec_valid) ok = 1'b0;
    end
    chk("out_flush_hold", 96'(ok), 96'd1);
    @(posedge clock); #1;
    vec_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    drain(20, "out_flush_drain");

    // Asynchronous reset while a vector is waiting.
    @(posedge clock); #1;
    vec_ready = 1'b0;
    push_word(32'h7777_0001);
    push_word(32'h7777_0002);
    push_word(32'h7777_0003);
    wait_valid(30, "rst_valid");
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 96'(vec_valid), 96'd0);
    chk("async_rst_dout",  vec_dout,       96'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    hs_cnt = 0;
    vec_ready = 1'b1;
    push_vec(32'h9999_0001, 32'h9999_0002, 32'h9999_0003, 96'h99990003_99990002_99990001);
    drain(40, "post_rst_drain");
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      push_vec(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].exp);
    end
    drain(100, "replay_drain");
    chk("handshake_total", 96'(hs_cnt), 96'd5);

`ifdef DIVIDE_COLLECT_CNT_EN
    chk("vec_count_5", 96'(vec_count), 96'd5);
    @(negedge clock);
    force dut.r_vec_count = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.r_vec_count;
    @(posedge clock); #1;
    push_vec(tbl[3].w0, tbl[3].w1, tbl[3].w2, tbl[3].exp);
    drain(40, "wrap_drain");
    chk("vec_count_wrap", 96'(vec_count), 96'd0);
`endif

    chk("rd_en_while_empty", 96'(rd_viol), 96'd0);
    chk("fifo_consumed", 96'(fifo_q.size()), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
